// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU and a DMA requester.
// Each grant holds the memory strobes for WAIT_CYCLES cycles, then pulses the grantee's ready.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dma_read,
    input  logic              dma_write,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    // Counter holds WAIT_CYCLES-1 down to 0, so $clog2(WAIT_CYCLES) bits suffice.
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  count;
    logic              op_write;
    logic              last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              cpu_req;
    logic              dma_req;
    logic              grant_valid;
    logic              grant_dma;

    assign cpu_req = cpu_read | cpu_write;
    assign dma_req = dma_read | dma_write;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            op_write   <= 1'b0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            state <= state_next;
            if (grant_valid) begin
                owner      <= grant_dma;
                last_grant <= grant_dma;
                // A request with both read and write high is a write.
                op_write   <= grant_dma ? dma_write : cpu_write;
                addr_q     <= grant_dma ? dma_addr  : cpu_addr;
                wdata_q    <= grant_dma ? dma_wdata : cpu_wdata;
                count      <= CNT_W'(WAIT_CYCLES - 1);
            end else if (state == ACCESS) begin
                if (count != '0) begin
                    count <= count - 1'b1;
                end else if (!op_write) begin
                    if (owner) begin
                        dma_rdata <= mem_rdata;
                    end else begin
                        cpu_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        grant_dma   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    grant_valid = 1'b1;
                    // On a tie the requester that did not win last time goes first.
                    grant_dma   = dma_req && (!cpu_req || !last_grant);
                    state_next  = ACCESS;
                end
            end
            ACCESS: begin
                if (count == '0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_read  = (state == ACCESS) && !op_write;
        mem_write = (state == ACCESS) && op_write;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        cpu_ready = (state == DONE) && !owner;
        dma_ready = (state == DONE) && owner;
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: tasks push expected transactions, a negedge
// monitor compares memory strobes and completions against the queue.
module tb_mem_port_arbiter;

    localparam int WAIT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        cpu_read, cpu_write, dma_read, dma_write;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ready, dma_ready, mem_read, mem_write, busy, owner;

    logic        w1_cpu_read, w1_cpu_write, w1_dma_read, w1_dma_write;
    logic [31:0] w1_cpu_addr, w1_cpu_wdata, w1_dma_addr, w1_dma_wdata;
    logic [31:0] w1_cpu_rdata, w1_dma_rdata, w1_mem_addr, w1_mem_wdata, w1_mem_rdata;
    logic        w1_cpu_ready, w1_dma_ready, w1_mem_read, w1_mem_write, w1_busy, w1_owner;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dma_read(dma_read), .dma_write(dma_write), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .rst(rst),
        .cpu_read(w1_cpu_read), .cpu_write(w1_cpu_write), .cpu_addr(w1_cpu_addr),
        .cpu_wdata(w1_cpu_wdata), .cpu_rdata(w1_cpu_rdata), .cpu_ready(w1_cpu_ready),
        .dma_read(w1_dma_read), .dma_write(w1_dma_write), .dma_addr(w1_dma_addr),
        .dma_wdata(w1_dma_wdata), .dma_rdata(w1_dma_rdata), .dma_ready(w1_dma_ready),
        .mem_read(w1_mem_read), .mem_write(w1_mem_write), .mem_addr(w1_mem_addr),
        .mem_wdata(w1_mem_wdata), .mem_rdata(w1_mem_rdata), .busy(w1_busy), .owner(w1_owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          own;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] cpu_rd;
        logic [31:0] dma_rd;
    } txn_t;

    txn_t        sb[$];
    txn_t        mon_e;
    int          strobe_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] exp_cpu_rd = 0;
    logic [31:0] exp_dma_rd = 0;

    always @(posedge clk) cyc++;

    // Monitor: every strobe cycle must match the queue head; every ready pops it.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            strobe_cnt = 0;
        end else begin
            vectors++;
            if (busy !== (mem_read | mem_write | cpu_ready | dma_ready)) begin
                miscompares++;
                $display("FAIL busy_decode: got %b expected %b", busy, mem_read | mem_write | cpu_ready | dma_ready);
            end
            if (mem_read || mem_write) begin
                if (sb.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_strobe: got rd=%b wr=%b expected no access", mem_read, mem_write);
                end else begin
                    mon_e = sb[0];
                    vectors++;
                    if ({mem_write, mem_read} !== (mon_e.wr ? 2'b10 : 2'b01)) begin
                        miscompares++;
                        $display("FAIL strobe_kind: got wr/rd=%b%b expected write=%b", mem_write, mem_read, mon_e.wr);
                    end
                    vectors++;
                    if (mem_addr !== mon_e.addr) begin
                        miscompares++;
                        $display("FAIL mem_addr: got %h expected %h", mem_addr, mon_e.addr);
                    end
                    if (mon_e.wr) begin
                        vectors++;
                        if (mem_wdata !== mon_e.wdata) begin
                            miscompares++;
                            $display("FAIL mem_wdata: got %h expected %h", mem_wdata, mon_e.wdata);
                        end
                    end
                    strobe_cnt++;
                end
            end
            if (cpu_ready || dma_ready) begin
                if (sb.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_ready: got cpu=%b dma=%b expected none", cpu_ready, dma_ready);
                end else begin
                    mon_e = sb.pop_front();
                    vectors++;
                    if ({cpu_ready, dma_ready} !== (mon_e.own ? 2'b01 : 2'b10)) begin
                        miscompares++;
                        $display("FAIL ready_pair: got cpu/dma=%b%b expected owner %0d", cpu_ready, dma_ready, mon_e.own);
                    end
                    vectors++;
                    if (owner !== mon_e.own) begin
                        miscompares++;
                        $display("FAIL owner: got %b expected %b", owner, mon_e.own);
                    end
                    vectors++;
                    if (strobe_cnt != WAIT) begin
                        miscompares++;
                        $display("FAIL strobe_len: got %0d expected %0d", strobe_cnt, WAIT);
                    end
                    vectors++;
                    if (cpu_rdata !== mon_e.cpu_rd) begin
                        miscompares++;
                        $display("FAIL cpu_rdata: got %h expected %h", cpu_rdata, mon_e.cpu_rd);
                    end
                    vectors++;
                    if (dma_rdata !== mon_e.dma_rd) begin
                        miscompares++;
                        $display("FAIL dma_rdata: got %h expected %h", dma_rdata, mon_e.dma_rd);
                    end
                end
                strobe_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit own, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        sb.push_back('{own: own, wr: wr, addr: addr, wdata: wdata, cpu_rd: exp_cpu_rd, dma_rd: exp_dma_rd});
    endtask

    // Returns 0 for cpu_ready, 1 for dma_ready, -1 on timeout.
    task automatic wait_ready(output int which);
        bit found = 0;
        which = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cpu_ready || dma_ready) begin
                which = dma_ready ? 1 : 0;
                found = 1;
                break;
            end
        end
        if (!found) begin
            vectors++; miscompares++;
            $display("FAIL ready_timeout: got no ready expected one within 40 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_read  = 1'($urandom);
            cpu_write = 1'($urandom);
            dma_read  = 1'($urandom);
            dma_write = 1'($urandom);
            cpu_addr  = $urandom;
            dma_addr  = $urandom;
            tick();
            vectors++;
            if ({mem_read, mem_write, cpu_ready, dma_ready, busy, owner} !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_ctrl: got %b expected 000000", {mem_read, mem_write, cpu_ready, dma_ready, busy, owner});
            end
            vectors++;
            if ({cpu_rdata, dma_rdata, mem_addr, mem_wdata} !== 128'b0) begin
                miscompares++;
                $display("FAIL reset_data: got %h %h %h %h expected zeros", cpu_rdata, dma_rdata, mem_addr, mem_wdata);
            end
        end
        {cpu_read, cpu_write, dma_read, dma_write} = 4'b0;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({mem_read, mem_write, cpu_ready, dma_ready, busy, owner} !== 6'b0) begin
                miscompares++;
                $display("FAIL idle_after_reset: got %b expected 000000", {mem_read, mem_write, cpu_ready, dma_ready, busy, owner});
            end
        end
    endtask

    task automatic test_cpu_read();
        int which;
        mem_rdata  = 32'hDEADBEEF;
        exp_cpu_rd = 32'hDEADBEEF;
        push(1'b0, 1'b0, 32'h10, 32'h0);
        cpu_addr = 32'h10;
        cpu_read = 1'b1;
        wait_ready(which);
        vectors++;
        if (which != 0) begin
            miscompares++;
            $display("FAIL cpu_read_grantee: got %0d expected 0", which);
        end
        cpu_read = 1'b0;
        tick();
        vectors++;
        if ({cpu_ready, dma_ready, busy} !== 3'b0) begin
            miscompares++;
            $display("FAIL cpu_read_single_pulse: got %b expected 000", {cpu_ready, dma_ready, busy});
        end
    endtask

    task automatic test_dma_write();
        int which;
        mem_rdata = 32'hFFFF0000;
        push(1'b1, 1'b1, 32'h20, 32'h12345678);
        dma_addr  = 32'h20;
        dma_wdata = 32'h12345678;
        dma_write = 1'b1;
        wait_ready(which);
        vectors++;
        if (which != 1) begin
            miscompares++;
            $display("FAIL dma_write_grantee: got %0d expected 1", which);
        end
        dma_write = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int which;
        int t [4];
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cpu_rd = 32'h0BADF00D;
        exp_dma_rd = 32'h0;
        mem_rdata  = 32'h0BADF00D;
        cpu_addr   = 32'h30;
        dma_addr   = 32'h34;
        dma_wdata  = 32'hCAFE0001;
        cpu_read   = 1'b1;
        dma_write  = 1'b1;
        for (int k = 0; k < 4; k++) push(k[0], k[0], k[0] ? 32'h34 : 32'h30, 32'hCAFE0001);
        for (int k = 0; k < 4; k++) begin
            wait_ready(which);
            t[k] = cyc;
            vectors++;
            if (which != k % 2) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d", k, which, k % 2);
            end
            if (k > 0) begin
                vectors++;
                if (t[k] - t[k-1] != WAIT + 2) begin
                    miscompares++;
                    $display("FAIL rr_spacing[%0d]: got %0d expected %0d", k, t[k] - t[k-1], WAIT + 2);
                end
            end
        end
        cpu_read  = 1'b0;
        dma_write = 1'b0;
        tick();
    endtask

    task automatic test_reset_midwrite();
        int which;
        cpu_addr  = 32'h50;
        cpu_wdata = 32'h77;
        cpu_write = 1'b1;
        push(1'b0, 1'b1, 32'h50, 32'h77);
        tick();
        tick();
        vectors++;
        if (mem_write !== 1'b1) begin
            miscompares++;
            $display("FAIL midwrite_strobe: got %b expected 1", mem_write);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({mem_write, mem_read, busy, cpu_ready} !== 4'b0) begin
            miscompares++;
            $display("FAIL midwrite_async_drop: got %b expected 0000", {mem_write, mem_read, busy, cpu_ready});
        end
        cpu_write = 1'b0;
        tick();
        vectors++;
        if (cpu_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midwrite_no_ready: got %b expected 0", cpu_ready);
        end
        rst = 1'b0;
        exp_dma_rd = 32'h0;
        mem_rdata  = 32'h13572468;
        exp_cpu_rd = 32'h13572468;
        push(1'b0, 1'b0, 32'h58, 32'h0);
        exp_dma_rd = 32'h13572468;
        push(1'b1, 1'b0, 32'h5C, 32'h0);
        cpu_addr = 32'h58;
        dma_addr = 32'h5C;
        cpu_read = 1'b1;
        dma_read = 1'b1;
        wait_ready(which);
        vectors++;
        if (which != 0) begin
            miscompares++;
            $display("FAIL post_reset_first_grant: got %0d expected 0", which);
        end
        cpu_read = 1'b0;
        wait_ready(which);
        vectors++;
        if (which != 1) begin
            miscompares++;
            $display("FAIL post_reset_second_grant: got %0d expected 1", which);
        end
        dma_read = 1'b0;
        tick();
    endtask

    task automatic test_rw_both();
        int which;
        mem_rdata  = 32'h11;
        exp_cpu_rd = 32'h11;
        push(1'b0, 1'b0, 32'h44, 32'h0);
        cpu_addr = 32'h44;
        cpu_read = 1'b1;
        wait_ready(which);
        cpu_read = 1'b0;
        tick();
        mem_rdata = 32'hFFFFFFFF;
        push(1'b0, 1'b1, 32'h40, 32'hA5A5A5A5);
        cpu_addr  = 32'h40;
        cpu_wdata = 32'hA5A5A5A5;
        cpu_read  = 1'b1;
        cpu_write = 1'b1;
        wait_ready(which);
        vectors++;
        if (which != 0) begin
            miscompares++;
            $display("FAIL rw_both_grantee: got %0d expected 0", which);
        end
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        tick();
    endtask

    task automatic test_wait1();
        w1_mem_rdata = 32'h5555AAAA;
        w1_cpu_addr  = 32'h60;
        w1_cpu_read  = 1'b1;
        tick();
        vectors++;
        if ({w1_mem_read, w1_cpu_ready} !== 2'b10 || w1_mem_addr !== 32'h60) begin
            miscompares++;
            $display("FAIL w1_strobe: got rd/rdy=%b%b addr=%h expected 10 addr=00000060", w1_mem_read, w1_cpu_ready, w1_mem_addr);
        end
        tick();
        vectors++;
        if ({w1_mem_read, w1_cpu_ready, w1_dma_ready} !== 3'b010) begin
            miscompares++;
            $display("FAIL w1_ready: got rd/rdy/drdy=%b expected 010", {w1_mem_read, w1_cpu_ready, w1_dma_ready});
        end
        vectors++;
        if (w1_cpu_rdata !== 32'h5555AAAA) begin
            miscompares++;
            $display("FAIL w1_rdata: got %h expected 5555aaaa", w1_cpu_rdata);
        end
        w1_cpu_read = 1'b0;
        tick();
        vectors++;
        if ({w1_cpu_ready, w1_busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL w1_idle: got rdy/busy=%b expected 00", {w1_cpu_ready, w1_busy});
        end
    endtask

    initial begin
        {cpu_read, cpu_write, dma_read, dma_write} = 4'b0;
        cpu_addr = 0; cpu_wdata = 0; dma_addr = 0; dma_wdata = 0; mem_rdata = 0;
        {w1_cpu_read, w1_cpu_write, w1_dma_read, w1_dma_write} = 4'b0;
        w1_cpu_addr = 0; w1_cpu_wdata = 0; w1_dma_addr = 0; w1_dma_wdata = 0; w1_mem_rdata = 0;

        test_reset();
        test_cpu_read();
        test_dma_write();
        test_back_to_back();
        test_reset_midwrite();
        test_rw_both();
        test_wait1();

        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port data/instruction memory between the multicycle CPU core and a DMA requester. Each requester uses a level-request / one-cycle-ready handshake. The block applies round-robin arbitration, drives the memory strobes for a fixed, parameterised access time, and returns read data in a per-requester holding register. It sits between the CPU memory port (MemRead/MemWrite/MemoryAddress/WriteDataMem/MemoryOut) and the memory model.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
WAIT_CYCLES, 2, cycles mem_read/mem_write stay asserted per access (legal range >=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
cpu_read  input  1  CPU read request (level)
cpu_write  input  1  CPU write request (level)
cpu_addr  input  ADDR_W  CPU address
cpu_wdata  input  DATA_W  CPU write data
cpu_rdata  output  DATA_W  CPU read data holding register
cpu_ready  output  1  one-cycle completion pulse to CPU
dma_read  input  1  DMA read request (level)
dma_write  input  1  DMA write request (level)
dma_addr  input  ADDR_W  DMA address
dma_wdata  input  DATA_W  DMA write data
dma_rdata  output  DATA_W  DMA read data holding register
dma_ready  output  1  one-cycle completion pulse to DMA
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data
busy  output  1  high while in ACCESS or DONE
owner  output  1  current/last grantee: 0 = CPU, 1 = DMA

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, all strobes, ready outputs and busy=0, mem_addr/mem_wdata=0, cpu_rdata/dma_rdata=0, last_grant=DMA (CPU wins first tie), owner=0. A write truncated by reset is not retried.
- Request: requester asserts read or write and holds addr/wdata stable until its ready pulse. On the edge where ready is sampled high, it drops the request or presents the next one.
- Request with both read and write high: treated as a write. Read data is not updated.
- FSM IDLE -> ACCESS -> DONE -> IDLE.
- IDLE: strobes low. At the clock edge, if any request is present:
  - Single requester: grant it.
  - Both requesting: grant the one opposite last_grant.
  - On grant: latch owner, op, addr, wdata; set last_grant=owner; load counter=WAIT_CYCLES-1; go to ACCESS.
- ACCESS: mem_read/mem_write reflect the latched op; mem_addr/mem_wdata come from latched registers (stable for exactly WAIT_CYCLES cycles).
  - counter>0: decrement.
  - counter==0: on a read, capture mem_rdata into the owner's rdata register; go to DONE.
- DONE: strobes low; owner's ready=1 for exactly this cycle; the other ready=0; next state IDLE.
- Latency: request sampled at edge E0 gives strobes during cycles 1..WAIT_CYCLES and ready in cycle WAIT_CYCLES+1. Minimum spacing between grants is WAIT_CYCLES+2 cycles (one IDLE cycle always intervenes).
- Non-owner requests are ignored until IDLE; there is no preemption.
- Non-owning rdata register holds its value. Each rdata register changes only on completion of its own read.
- All outputs are registered or decoded from registered state; there is no combinational path from request inputs to mem_* outputs.
- busy=1 in ACCESS and DONE. owner holds the last grantee while in IDLE.

Test Plan:
- Reset: hold rst=1 with random requests -> all strobes, ready, busy=0; rdata=0; owner=0. Release rst -> outputs stay idle until the first request edge.
- CPU read alone, WAIT_CYCLES=2, cpu_addr=0x10, mem_rdata=0xDEADBEEF -> mem_read=1, mem_addr=0x10 for exactly 2 cycles; then cpu_ready=1 for 1 cycle; cpu_rdata=0xDEADBEEF; dma_ready stays 0.
- DMA write alone, dma_addr=0x20, dma_wdata=0x12345678 -> mem_write=1 for 2 cycles with those values; dma_ready one pulse; dma_rdata unchanged (0).
- Both requesting continuously from reset -> grant order CPU, DMA, CPU, DMA; ready pulses spaced 4 cycles apart (WAIT_CYCLES=2), alternating requesters.
- rst pulsed in the 2nd ACCESS cycle of a CPU write -> mem_write drops immediately; no cpu_ready. After release, with both requesting, CPU is granted first.
- CPU read+write both high, addr=0x40, wdata=0xA5A5A5A5, prior cpu_rdata=0x11 -> mem_write performed, mem_read stays 0, cpu_rdata remains 0x11. Repeat CPU read with WAIT_CYCLES=1 -> 1-cycle strobe, ready in cycle 2.
